// File: rtl/classifier_mem_topic_nway_pkg.sv
// Shared defaults, scrubber state encoding and small helpers for the topic
// classification memory.
package classifier_mem_topic_nway_pkg;

   localparam int DEF_NUM_WAYS          = 2;
   localparam int DEF_DEPTH_NBITS       = 10;
   localparam int DEF_BUCKET_NBITS      = 64;
   localparam int DEF_VALUE_DEPTH_NBITS = 10;
   localparam int DEF_KEY_NBITS         = 64;
   localparam int DEF_ETIME_NBITS       = 32;

   typedef enum logic [2:0] {
      SCRUB_IDLE   = 3'd0,
      SCRUB_READ   = 3'd1,
      SCRUB_CHECK  = 3'd2,
      SCRUB_CLEAR  = 3'd3,
      SCRUB_REPORT = 3'd4
   } scrub_state_t;

   function automatic int max_nbits(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/classifier_mem_topic_nway_if.sv
// Bus bundle between the classifier (master) and the topic memory (slave).
interface classifier_mem_topic_nway_if
   import classifier_mem_topic_nway_pkg::*;
#(
   parameter int NUM_WAYS          = DEF_NUM_WAYS,
   parameter int DEPTH_NBITS       = DEF_DEPTH_NBITS,
   parameter int BUCKET_NBITS      = DEF_BUCKET_NBITS,
   parameter int VALUE_DEPTH_NBITS = DEF_VALUE_DEPTH_NBITS,
   parameter int KEY_NBITS         = DEF_KEY_NBITS,
   parameter int ETIME_NBITS       = DEF_ETIME_NBITS
);
   logic [NUM_WAYS-1:0]              ht_rd;
   logic [NUM_WAYS*DEPTH_NBITS-1:0]  ht_raddr;
   logic [NUM_WAYS-1:0]              ht_wr;
   logic [NUM_WAYS*DEPTH_NBITS-1:0]  ht_waddr;
   logic [NUM_WAYS*BUCKET_NBITS-1:0] ht_wdata;
   logic [NUM_WAYS-1:0]              ht_ack;
   logic [NUM_WAYS*BUCKET_NBITS-1:0] ht_rdata;
   logic                             key_rd;
   logic [VALUE_DEPTH_NBITS-1:0]     key_raddr;
   logic                             key_wr;
   logic [VALUE_DEPTH_NBITS-1:0]     key_waddr;
   logic [KEY_NBITS-1:0]             key_wdata;
   logic                             key_ack;
   logic [KEY_NBITS-1:0]             key_rdata;
   logic                             etime_set;
   logic [VALUE_DEPTH_NBITS-1:0]     etime_tid;
   logic [ETIME_NBITS-1:0]           etime_val;
   logic                             etime_rd;
   logic [VALUE_DEPTH_NBITS-1:0]     etime_raddr;
   logic                             etime_ack;
   logic [ETIME_NBITS-1:0]           etime_rdata;
   logic [ETIME_NBITS-1:0]           now_time;
   logic                             scrub_en;
   logic                             expire_valid;
   logic [VALUE_DEPTH_NBITS-1:0]     expire_tid;
   logic                             expire_ready;
   logic                             init_done;

   modport master (
      output ht_rd, ht_raddr, ht_wr, ht_waddr, ht_wdata,
             key_rd, key_raddr, key_wr, key_waddr, key_wdata,
             etime_set, etime_tid, etime_val, etime_rd, etime_raddr,
             now_time, scrub_en, expire_ready,
      input  ht_ack, ht_rdata, key_ack, key_rdata, etime_ack, etime_rdata,
             expire_valid, expire_tid, init_done
   );

   modport slave (
      input  ht_rd, ht_raddr, ht_wr, ht_waddr, ht_wdata,
             key_rd, key_raddr, key_wr, key_waddr, key_wdata,
             etime_set, etime_tid, etime_val, etime_rd, etime_raddr,
             now_time, scrub_en, expire_ready,
      output ht_ack, ht_rdata, key_ack, key_rdata, etime_ack, etime_rdata,
             expire_valid, expire_tid, init_done
   );
endinterface

// File: rtl/classifier_topic_scrubber.sv
// Background aging scrubber: walks every TID, retires entries whose expiry time
// has passed and hands each retired TID to the classifier.
module classifier_topic_scrubber
   import classifier_mem_topic_nway_pkg::*;
#(
   parameter int TID_NBITS   = DEF_VALUE_DEPTH_NBITS,
   parameter int ETIME_NBITS = DEF_ETIME_NBITS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   scrub_en,
   input  logic                   init_done,
   input  logic                   app_rd,
   input  logic [ETIME_NBITS-1:0] etime_rdata,
   input  logic [ETIME_NBITS-1:0] now_time,
   input  logic                   clear_ok,
   input  logic                   refresh,
   input  logic                   expire_ready,
   output logic                   rd,
   output logic                   clr,
   output logic                   expire_valid,
   output logic [TID_NBITS-1:0]   idx
);
   scrub_state_t state_reg, state_next;
   logic [TID_NBITS-1:0] idx_reg, idx_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= SCRUB_IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      rd           = 1'b0;
      clr          = 1'b0;
      expire_valid = 1'b0;
      case (state_reg)
         SCRUB_IDLE: if (scrub_en && init_done) state_next = SCRUB_READ;
         SCRUB_READ: begin
            // the application's etime read owns the port whenever it asks
            if (!app_rd) begin
               rd         = 1'b1;
               state_next = SCRUB_CHECK;
            end
         end
         SCRUB_CHECK: begin
            if (!refresh && etime_rdata != '0 && etime_rdata <= now_time) begin
               state_next = SCRUB_CLEAR;
            end else begin
               idx_next   = idx_reg + TID_NBITS'(1);
               state_next = SCRUB_IDLE;
            end
         end
         SCRUB_CLEAR: begin
            if (refresh) begin
               idx_next   = idx_reg + TID_NBITS'(1);
               state_next = SCRUB_IDLE;
            end else if (clear_ok) begin
               clr        = 1'b1;
               state_next = SCRUB_REPORT;
            end
         end
         SCRUB_REPORT: begin
            expire_valid = 1'b1;
            if (expire_ready) begin
               idx_next   = idx_reg + TID_NBITS'(1);
               state_next = SCRUB_IDLE;
            end
         end
         default: state_next = SCRUB_IDLE;
      endcase
   end

   assign idx = idx_reg;
endmodule

// File: rtl/ram_1r1w.sv
// Simple dual-port RAM: one registered read port, one write port; a same-address
// read/write in one cycle returns the old contents.
module ram_1r1w #(
   parameter int ADDR_NBITS = 10,
   parameter int DATA_NBITS = 64
) (
   input  logic                  clk,
   input  logic                  re,
   input  logic [ADDR_NBITS-1:0] raddr,
   output logic [DATA_NBITS-1:0] rdata,
   input  logic                  we,
   input  logic [ADDR_NBITS-1:0] waddr,
   input  logic [DATA_NBITS-1:0] wdata
);
   logic [DATA_NBITS-1:0] mem [2**ADDR_NBITS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/classifier_mem_topic_nway.sv
// Topic-classification memory: NUM_WAYS hash-bucket tables plus per-TID key and
// expiry tables, zero-swept after reset, with an aging scrubber on the TID tables.
module classifier_mem_topic_nway
   import classifier_mem_topic_nway_pkg::*;
#(
   parameter int NUM_WAYS          = DEF_NUM_WAYS,
   parameter int DEPTH_NBITS       = DEF_DEPTH_NBITS,
   parameter int BUCKET_NBITS      = DEF_BUCKET_NBITS,
   parameter int VALUE_DEPTH_NBITS = DEF_VALUE_DEPTH_NBITS,
   parameter int KEY_NBITS         = DEF_KEY_NBITS,
   parameter int ETIME_NBITS       = DEF_ETIME_NBITS
) (
   input logic clk,
   input logic rst,
   classifier_mem_topic_nway_if.slave bus
);
   localparam int SWEEP_NBITS = max_nbits(DEPTH_NBITS, VALUE_DEPTH_NBITS);

   logic [SWEEP_NBITS-1:0]       sweep_cnt_reg;
   logic                         init_done_reg;
   logic                         sweep, ht_sweep_we, val_sweep_we;
   logic [DEPTH_NBITS-1:0]       ht_sweep_addr;
   logic [VALUE_DEPTH_NBITS-1:0] val_sweep_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_cnt_reg <= '0;
         init_done_reg <= 1'b0;
      end else if (!init_done_reg) begin
         sweep_cnt_reg <= sweep_cnt_reg + SWEEP_NBITS'(1);
         if (&sweep_cnt_reg) init_done_reg <= 1'b1;
      end
   end

   // a shallower RAM skips sweep addresses beyond its own depth
   assign sweep          = !init_done_reg;
   assign ht_sweep_we    = sweep && ((sweep_cnt_reg >> DEPTH_NBITS) == '0);
   assign val_sweep_we   = sweep && ((sweep_cnt_reg >> VALUE_DEPTH_NBITS) == '0);
   assign ht_sweep_addr  = sweep_cnt_reg[DEPTH_NBITS-1:0];
   assign val_sweep_addr = sweep_cnt_reg[VALUE_DEPTH_NBITS-1:0];
   assign bus.init_done  = init_done_reg;

   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic                    wr_reg, ack_reg;
      logic [DEPTH_NBITS-1:0]  waddr_reg;
      logic [BUCKET_NBITS-1:0] wdata_reg, rdata;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_reg  <= 1'b0;
            ack_reg <= 1'b0;
         end else begin
            wr_reg  <= bus.ht_wr[gi] && init_done_reg;
            ack_reg <= bus.ht_rd[gi];
         end
      end

      always_ff @(posedge clk) begin
         waddr_reg <= bus.ht_waddr[gi*DEPTH_NBITS +: DEPTH_NBITS];
         wdata_reg <= bus.ht_wdata[gi*BUCKET_NBITS +: BUCKET_NBITS];
      end

      ram_1r1w #(.ADDR_NBITS(DEPTH_NBITS), .DATA_NBITS(BUCKET_NBITS)) u_ram (
         .clk   (clk),
         .re    (bus.ht_rd[gi]),
         .raddr (bus.ht_raddr[gi*DEPTH_NBITS +: DEPTH_NBITS]),
         .rdata (rdata),
         .we    (ht_sweep_we || wr_reg),
         .waddr (sweep ? ht_sweep_addr : waddr_reg),
         .wdata (sweep ? '0 : wdata_reg)
      );

      assign bus.ht_ack[gi] = ack_reg;
      assign bus.ht_rdata[gi*BUCKET_NBITS +: BUCKET_NBITS] = rdata;
   end

   logic                         key_wr_reg, key_ack_reg, etime_wr_reg, etime_ack_reg;
   logic [VALUE_DEPTH_NBITS-1:0] key_waddr_reg, etime_waddr_reg, scrub_idx;
   logic [KEY_NBITS-1:0]         key_wdata_reg, key_q;
   logic [ETIME_NBITS-1:0]       etime_wdata_reg, etime_q;
   logic                         scrub_rd, scrub_clr, refresh, clear_ok, expire_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_wr_reg    <= 1'b0;
         etime_wr_reg  <= 1'b0;
         key_ack_reg   <= 1'b0;
         etime_ack_reg <= 1'b0;
      end else begin
         key_wr_reg    <= bus.key_wr && init_done_reg;
         etime_wr_reg  <= bus.etime_set && init_done_reg;
         key_ack_reg   <= bus.key_rd;
         etime_ack_reg <= bus.etime_rd;
      end
   end

   always_ff @(posedge clk) begin
      key_waddr_reg   <= bus.key_waddr;
      key_wdata_reg   <= bus.key_wdata;
      etime_waddr_reg <= bus.etime_tid;
      etime_wdata_reg <= bus.etime_val;
   end

   ram_1r1w #(.ADDR_NBITS(VALUE_DEPTH_NBITS), .DATA_NBITS(KEY_NBITS)) u_key_ram (
      .clk   (clk),
      .re    (bus.key_rd),
      .raddr (bus.key_raddr),
      .rdata (key_q),
      .we    (val_sweep_we || key_wr_reg || scrub_clr),
      .waddr (sweep ? val_sweep_addr : (key_wr_reg ? key_waddr_reg : scrub_idx)),
      .wdata ((key_wr_reg && !sweep) ? key_wdata_reg : '0)
   );

   ram_1r1w #(.ADDR_NBITS(VALUE_DEPTH_NBITS), .DATA_NBITS(ETIME_NBITS)) u_etime_ram (
      .clk   (clk),
      .re    (bus.etime_rd || scrub_rd),
      .raddr (bus.etime_rd ? bus.etime_raddr : scrub_idx),
      .rdata (etime_q),
      .we    (val_sweep_we || etime_wr_reg || scrub_clr),
      .waddr (sweep ? val_sweep_addr : (etime_wr_reg ? etime_waddr_reg : scrub_idx)),
      .wdata ((etime_wr_reg && !sweep) ? etime_wdata_reg : '0)
   );

   // a write to the entry under inspection, strobed or still staged, means it was refreshed
   assign refresh  = (bus.etime_set && bus.etime_tid == scrub_idx)
                  || (bus.key_wr && bus.key_waddr == scrub_idx)
                  || (etime_wr_reg && etime_waddr_reg == scrub_idx)
                  || (key_wr_reg && key_waddr_reg == scrub_idx);
   assign clear_ok = !key_wr_reg && !etime_wr_reg;

   classifier_topic_scrubber #(.TID_NBITS(VALUE_DEPTH_NBITS), .ETIME_NBITS(ETIME_NBITS)) u_scrub (
      .clk          (clk),
      .rst          (rst),
      .scrub_en     (bus.scrub_en),
      .init_done    (init_done_reg),
      .app_rd       (bus.etime_rd),
      .etime_rdata  (etime_q),
      .now_time     (bus.now_time),
      .clear_ok     (clear_ok),
      .refresh      (refresh),
      .expire_ready (bus.expire_ready),
      .rd           (scrub_rd),
      .clr          (scrub_clr),
      .expire_valid (expire_valid),
      .idx          (scrub_idx)
   );

   assign bus.key_ack      = key_ack_reg;
   assign bus.key_rdata    = key_q;
   assign bus.etime_ack    = etime_ack_reg;
   assign bus.etime_rdata  = etime_q;
   assign bus.expire_valid = expire_valid;
   assign bus.expire_tid   = scrub_idx;
endmodule
